// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: state encoding, instruction
// field positions and the branch-offset helper.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_e;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int IMM_W     = 16;
  localparam int JADDR_W   = 26;

  // Sign-extended, word-scaled branch displacement.
  function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(32 - IMM_W - 2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump > branch > sequential, all mod 2^32.
// Only the low JADDR_W instruction bits matter here (jump index / branch immediate).
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0]        pc,
  input  logic [JADDR_W-1:0] instr,
  input  logic               pcsrc,
  input  logic               jump,
  output logic [31:0]        next_pc,
  output logic [31:0]        pc_plus4
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + branch_offset(instr[IMM_W-1:0]);
  assign jump_target   = {pc_plus4[31:28], instr, 2'b00};

  always_comb begin
    if (jump)       next_pc = jump_target;
    else if (pcsrc) next_pc = branch_target;
    else            next_pc = pc_plus4;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory,
// presents the latched instruction for one EXEC phase and guards fetches with a watchdog.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic        exec_stall,
  output logic        fetch_err
);

  localparam bit            WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0] cnt_inc;
  logic [31:0]     next_pc;

  next_pc_calc u_next_pc (
    .pc       (pc_q),
    .instr    (instr_q[JADDR_W-1:0]),
    .pcsrc    (pcsrc),
    .jump     (jump),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

  assign cnt_inc = cnt_q + TO_W'(1);

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (!halt) state_d = ST_FETCH;
      ST_FETCH: begin
        // Data arriving on the timeout edge still completes the fetch.
        if (imem_valid) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end else begin
          cnt_d = cnt_inc;
          if (WD_EN && (cnt_inc == TO_LIMIT)) state_d = ST_ERROR;
        end
      end
      ST_EXEC: begin
        if (!exec_stall) begin
          pc_d    = next_pc;
          state_d = halt ? ST_IDLE : ST_FETCH;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decode straight from state so reset drops imem_req without a clock.
  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign fetch_err   = (state_q == ST_ERROR);
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[OP_MSB:OP_LSB];
  assign funct       = instr_q[FUNCT_MSB:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of chained instructions plus hand-written
// stall, asynchronous-reset and watchdog sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pcsrc = 1'b0;
  logic        jump = 1'b0;
  logic        exec_stall = 1'b0;
  logic        fetch_err;
  logic        mem_en = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  // Zero-wait memory: answers in the same cycle whenever enabled.
  assign imem_valid = imem_req & mem_en;

  fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (16),
    .TO_W           (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .exec_stall  (exec_stall),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        ps;
    logic        jp;
    logic [31:0] addr;
    logic [5:0]  op;
    logic [5:0]  funct;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    check("fetch_reached", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic watchdog_run(input bit late_valid);
    halt   = 1'b0;
    mem_en = 1'b0;
    do_reset();
    wait_fetch();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("wd%0d_req_c%0d", late_valid, k), {31'b0, imem_req}, 32'd1);
      check($sformatf("wd%0d_err_c%0d", late_valid, k), {31'b0, fetch_err}, 32'd0);
      if (late_valid && k == 15) begin
        imem_rdata = 32'h8C01_0004;
        mem_en     = 1'b1;
      end
      @(negedge clk);
    end
    if (late_valid) begin
      check("wd_late_valid_exec", {31'b0, instr_valid}, 32'd1);
      check("wd_late_valid_noerr", {31'b0, fetch_err}, 32'd0);
    end else begin
      check("wd_err_set", {31'b0, fetch_err}, 32'd1);
      check("wd_err_req", {31'b0, imem_req}, 32'd0);
      check("wd_err_ivalid", {31'b0, instr_valid}, 32'd0);
      mem_en = 1'b1;
      repeat (3) @(negedge clk);
      check("wd_err_sticky", {31'b0, fetch_err}, 32'd1);
      check("wd_err_sticky_req", {31'b0, imem_req}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("wd_err_cleared", {31'b0, fetch_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    //            word          ps    jp    addr at fetch  op     funct
    vecs[0]  = '{32'h8C01_0004, 1'b0, 1'b0, 32'h0000_0000, 6'h23, 6'h04};
    vecs[1]  = '{32'h8C01_0004, 1'b0, 1'b0, 32'h0000_0004, 6'h23, 6'h04};
    vecs[2]  = '{32'h1000_0003, 1'b0, 1'b0, 32'h0000_0008, 6'h04, 6'h03};
    vecs[3]  = '{32'h0800_0002, 1'b0, 1'b1, 32'h0000_000C, 6'h02, 6'h02};
    vecs[4]  = '{32'h1000_0003, 1'b1, 1'b0, 32'h0000_0008, 6'h04, 6'h03};
    vecs[5]  = '{32'h0800_0010, 1'b1, 1'b1, 32'h0000_0018, 6'h02, 6'h10};
    vecs[6]  = '{32'h1000_FFEE, 1'b1, 1'b0, 32'h0000_0040, 6'h04, 6'h2E};
    vecs[7]  = '{32'h8C01_0004, 1'b0, 1'b0, 32'hFFFF_FFFC, 6'h23, 6'h04};
    vecs[8]  = '{32'h1000_FFFD, 1'b1, 1'b0, 32'h0000_0000, 6'h04, 6'h3D};
    vecs[9]  = '{32'h0800_0010, 1'b1, 1'b1, 32'hFFFF_FFF8, 6'h02, 6'h10};
    vecs[10] = '{32'h8C01_0004, 1'b0, 1'b0, 32'hF000_0040, 6'h23, 6'h04};

    // Reset state
    rst_n  = 1'b0;
    halt   = 1'b0;
    mem_en = 1'b1;
    #3;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_ivalid", {31'b0, instr_valid}, 32'd0);
    check("rst_err", {31'b0, fetch_err}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Chained instruction table, zero-wait memory
    for (int i = 0; i < 11; i++) begin
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, 32'd1);
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("v%0d_fetch_ivalid", i), {31'b0, instr_valid}, 32'd0);
      imem_rdata = vecs[i].word;
      pcsrc      = vecs[i].ps;
      jump       = vecs[i].jp;
      @(negedge clk);
      check($sformatf("v%0d_ivalid", i), {31'b0, instr_valid}, 32'd1);
      check($sformatf("v%0d_exec_req", i), {31'b0, imem_req}, 32'd0);
      check($sformatf("v%0d_instr", i), instr, vecs[i].word);
      check($sformatf("v%0d_op", i), {26'b0, op}, {26'b0, vecs[i].op});
      check($sformatf("v%0d_funct", i), {26'b0, funct}, {26'b0, vecs[i].funct});
      check($sformatf("v%0d_pc", i), pc, vecs[i].addr);
      @(negedge clk);
    end
    check("tbl_final_addr", imem_addr, 32'hF000_0044);
    pcsrc = 1'b0;
    jump  = 1'b0;

    // exec_stall holds EXEC for three extra cycles; pcsrc toggles are ignored
    do_reset();
    wait_fetch();
    imem_rdata = 32'h1000_0003;
    exec_stall = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall_ivalid_c%0d", k), {31'b0, instr_valid}, 32'd1);
      check($sformatf("stall_pc_c%0d", k), pc, 32'h0);
      check($sformatf("stall_instr_c%0d", k), instr, 32'h1000_0003);
      if (k == 3) begin
        exec_stall = 1'b0;
        pcsrc      = 1'b0;
      end else begin
        pcsrc = (k % 2 == 0);
      end
      @(negedge clk);
    end
    check("stall_release_ivalid", {31'b0, instr_valid}, 32'd0);
    check("stall_release_req", {31'b0, imem_req}, 32'd1);
    check("stall_release_addr", imem_addr, 32'h4);

    // Asynchronous reset mid-FETCH, then halt keeps the unit idle
    mem_en = 1'b0;
    #2;
    rst_n = 1'b0;
    halt  = 1'b1;
    #1;
    check("async_rst_req", {31'b0, imem_req}, 32'd0);
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    mem_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("halt_idle_req_c%0d", k), {31'b0, imem_req}, 32'd0);
    end
    halt = 1'b0;
    @(negedge clk);
    check("unhalt_req", {31'b0, imem_req}, 32'd1);
    check("unhalt_addr", imem_addr, 32'h0);

    // Watchdog: timeout after 16 FETCH cycles, and valid on the 16th cycle wins
    watchdog_run(1'b0);
    watchdog_run(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle MIPS, directly upstream of control_unity.
- Owns the PC and runs a request/valid handshake to instruction memory.
- Presents the fetched word, its op/funct fields and a valid strobe to the control unit.
- Consumes control_unity's pcsrc/jump in the same cycle to compute and register the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, max cycles in FETCH without imem_valid before error; 0 disables the watchdog.
- TO_W, 8, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- halt  in  1  when high in IDLE, fetching does not start.
- imem_req  out  1  fetch request; held with stable imem_addr until accepted.
- imem_addr  out  32  word address = pc.
- imem_valid  in  1  read data valid; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction.
- op  out  6  instr[31:26], to control_unity.op.
- funct  out  6  instr[5:0], to control_unity.funct.
- instr_valid  out  1  high during EXEC; core executes instr this cycle.
- pc  out  32  PC of current instruction.
- pc_plus4  out  32  pc+4 (combinational).
- pcsrc  in  1  from control_unity; take branch; sampled in EXEC only.
- jump  in  1  from control_unity; take jump; sampled in EXEC only.
- exec_stall  in  1  holds EXEC (multi-cycle memory op etc.).
- fetch_err  out  1  sticky watchdog error.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, fetch_err=0, watchdog counter=0.
  - Reset mid-handshake abandons the request immediately; any late imem_valid is ignored because imem_req=0.
- States:
  - IDLE:
    - Outputs idle.
    - halt=0 -> FETCH next cycle; halt=1 -> stay IDLE.
  - FETCH:
    - imem_req=1, imem_addr=pc.
    - imem_valid=1 at an edge -> instr<=imem_rdata, counter<=0, -> EXEC.
    - Otherwise counter++.
    - Counter reaching TIMEOUT_CYCLES (when nonzero) -> ERROR.
    - imem_valid and timeout in the same cycle: valid wins.
  - EXEC:
    - instr_valid=1, imem_req=0.
    - exec_stall=1 -> stay EXEC, pc and instr held, pcsrc/jump ignored.
    - exec_stall=0 -> pc<=next_pc; -> IDLE if halt=1, else FETCH.
  - ERROR:
    - fetch_err=1, imem_req=0, instr_valid=0.
    - Only reset exits ERROR.
- next_pc:
  - Priority jump > pcsrc > sequential.
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - pcsrc: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - Otherwise: pc_plus4.
- Arithmetic:
  - All 32-bit, wrap-around modulo 2^32; pc=32'hFFFF_FFFC sequential -> 0.
- Latency:
  - Zero-wait memory (imem_valid in the first FETCH cycle) gives 2 cycles per instruction (FETCH, EXEC).
  - Each additional memory wait cycle adds 1.
- Output decoding:
  - op/funct decode from the registered instr; stable throughout EXEC.
  - Values outside EXEC are don't-care, but must be the last latched instr (no X).

Decomposition:
- Shared package mips_pkg:
  - State encoding typedef/localparams (IDLE, FETCH, EXEC, ERROR).
  - Opcode field positions (OP_MSB=31, OP_LSB=26, FUNCT_MSB=5), IMM_W=16, JADDR_W=26.
- One sub-module, next_pc_calc: combinational; inputs pc, instr, pcsrc, jump; outputs next_pc, pc_plus4.
- FSM, watchdog and registers stay in fetch_unit.

Test Plan:
- Reset, halt=0, memory answers every req same cycle with 32'h8C01_0004 (lw) -> imem_addr sequence 0,4,8; instr_valid pulses every 2nd cycle; op=6'b100011.
- In EXEC: instr=32'h1000_0003 (beq), pcsrc=1, pc=8 -> next imem_addr=8+4+12=24; same with pcsrc=0 -> 12.
- In EXEC: instr=32'h0800_0010, jump=1, pcsrc=1, pc=32'h1000_0000 -> next imem_addr=32'h1000_0040 (jump priority).
- Memory withholds imem_valid with TIMEOUT_CYCLES=16 -> fetch_err=1 after 16 FETCH cycles, imem_req=0, stays in ERROR until rst_n pulse; valid arriving on the 16th cycle -> no error.
- exec_stall=1 for 3 cycles in EXEC -> instr_valid high 4 cycles, pc unchanged, pcsrc toggling ignored until stall drops.
- Assert rst_n=0 mid-FETCH (imem_req=1) -> imem_req drops without clock edge, pc=RESET_PC; halt=1 after reset -> imem_req stays 0.
